// File: rtl/tick_sampler_pkg.sv
// Shared constants for the tick sampler and its divider: default widths,
// default period and capture mode encodings.
package tick_sampler_pkg;
    localparam int          TS_CNT_W          = 26;
    localparam int unsigned TS_DEFAULT_PERIOD = 24999999;

    localparam logic MODE_EVERY  = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;
endpackage

// File: rtl/tick_sampler_tick_gen.sv
// Programmable divider: emits a one-cycle sample strobe every period_reg+1
// enabled clk cycles, with pause and runtime period reload.
module tick_gen
    import tick_sampler_pkg::*;
#(
    parameter int          CNT_W          = TS_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = TS_DEFAULT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period_in,
    input  logic             period_load,
    output logic             sample
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_reg;

    // A load suppresses the event even when it lands on the terminal count.
    assign sample = en && !period_load && (cnt == period_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            period_reg <= CNT_W'(DEFAULT_PERIOD);
        end else if (period_load) begin
            cnt        <= '0;
            period_reg <= period_in;
        end else if (en) begin
            if (cnt == period_reg) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_sampler.sv
// Multi-channel slow-rate sampler with change-only capture and per-channel
// change flags. Define TICK_SAMPLER_SYNC_EN to add a 2-flop input synchroniser.
module tick_sampler
    import tick_sampler_pkg::*;
#(
    parameter int          CH             = 4,
    parameter int          WIDTH          = 1,
    parameter int          CNT_W          = TS_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = TS_DEFAULT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CNT_W-1:0]    period_in,
    input  logic                period_load,
    input  logic                mode,
    input  logic [CH*WIDTH-1:0] in,
    output logic [CH*WIDTH-1:0] out,
    output logic                tick,
    output logic                valid,
    output logic [CH-1:0]       changed
);

    logic                sample;
    logic [CH*WIDTH-1:0] in_s;
    logic [CH-1:0]       diff;

    tick_gen #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period_in   (period_in),
        .period_load (period_load),
        .sample      (sample)
    );

`ifdef TICK_SAMPLER_SYNC_EN
    logic [CH*WIDTH-1:0] sync1;
    logic [CH*WIDTH-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    assign in_s = sync2;
`else
    assign in_s = in;
`endif

    always_comb begin
        diff = '0;
        for (int k = 0; k < CH; k++) begin
            diff[k] = |(in_s[k*WIDTH +: WIDTH] ^ out[k*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            tick    <= 1'b0;
            valid   <= 1'b0;
            changed <= '0;
        end else begin
            tick  <= sample;
            valid <= 1'b0;
            if (sample) begin
                changed <= diff;
                // Change-only mode leaves out untouched when nothing moved.
                if (mode == MODE_EVERY || (|diff)) begin
                    out   <= in_s;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_sampler.sv
// Directed bench for tick_sampler with period 3, two 4-bit channels.
module tb_tick_sampler;
    localparam int CNT_W = 26;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] period_in;
    logic             period_load;
    logic             mode;
    logic [7:0]       in;
    logic [7:0]       out;
    logic             tick;
    logic             valid;
    logic [1:0]       changed;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tick_sampler #(
        .CH             (2),
        .WIDTH          (4),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period_in   (period_in),
        .period_load (period_load),
        .mode        (mode),
        .in          (in),
        .out         (out),
        .tick        (tick),
        .valid       (valid),
        .changed     (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic t, input logic v,
                             input logic [7:0] o, input logic [1:0] c);
        check({tag, ".tick"}, 32'(tick), 32'(t));
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".out"}, 32'(out), 32'(o));
        check({tag, ".changed"}, 32'(changed), 32'(c));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; in = 8'h00;
        period_in = '0; period_load = 1'b0;
        repeat (3) step();
        check_all("reset", 1'b0, 1'b0, 8'h00, 2'b00);

        // Sample every tick: events on cycles 4, 8, 12.
        rst = 1'b0; en = 1'b1; in = 8'hA5;
        for (int c = 1; c <= 12; c++) begin
            step();
            check("every.tick", 32'(tick), 32'(c % 4 == 0));
            check("every.valid", 32'(valid), 32'(c % 4 == 0));
            if (c >= 4) check("every.out", 32'(out), 32'h A5);
            if (c == 4) check("every.changed1", 32'(changed), 32'b11);
            if (c == 8) check("every.changed2", 32'(changed), 32'b00);
        end

        // Change-only mode, input steady.
        mode = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_all("hold", c == 4, 1'b0, 8'hA5, 2'b00);
        end

        // Change-only mode, channel 0 moves.
        in = 8'hA6;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("move.tick", 32'(tick), 32'b0);
        end
        step();
        check_all("move", 1'b1, 1'b1, 8'hA6, 2'b01);

        // Load period 0 exactly on the terminal-count cycle.
        repeat (3) step();
        period_load = 1'b1; period_in = '0;
        step();
        check("load.notick", 32'(tick), 32'b0);
        check("load.novalid", 32'(valid), 32'b0);
        period_load = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("p0.tick", 32'(tick), 32'b1);
            check("p0.valid", 32'(valid), 32'b0);
        end
        in = 8'h33;
`ifdef TICK_SAMPLER_SYNC_EN
        for (int c = 1; c <= 2; c++) begin
            step();
            check_all("p0.syncwait", 1'b1, 1'b0, 8'hA6, 2'b00);
        end
`endif
        step();
        check_all("p0.move", 1'b1, 1'b1, 8'h33, 2'b11);
        step();
        check_all("p0.steady", 1'b1, 1'b0, 8'h33, 2'b00);

        // Back to period 3, pause at cnt=2.
        period_load = 1'b1; period_in = CNT_W'(3);
        step();
        check("reload.notick", 32'(tick), 32'b0);
        period_load = 1'b0;
        repeat (2) step();
        check("pre_pause.tick", 32'(tick), 32'b0);
        en = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            check("pause.tick", 32'(tick), 32'b0);
        end
        en = 1'b1;
        step();
        check("resume1.tick", 32'(tick), 32'b0);
        step();
        check_all("resume2", 1'b1, 1'b0, 8'h33, 2'b00);

        // Mode 0 capture of A6, then reset at cnt=2.
        mode = 1'b0; in = 8'hA6;
        repeat (3) step();
        check("pre_rst.tick", 32'(tick), 32'b0);
        step();
        check_all("pre_rst", 1'b1, 1'b1, 8'hA6, 2'b11);
        repeat (2) step();
        rst = 1'b1;
        step();
        check_all("midrst", 1'b0, 1'b0, 8'h00, 2'b00);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("post_rst.tick", 32'(tick), 32'b0);
        end
        step();
        check_all("post_rst", 1'b1, 1'b1, 8'hA6, 2'b11);

        // Input changing 1 cycle before the terminal count.
        repeat (2) step();
        in = 8'h5A;
        step();
        step();
`ifdef TICK_SAMPLER_SYNC_EN
        check_all("late_change", 1'b1, 1'b1, 8'hA6, 2'b00);
`else
        check_all("late_change", 1'b1, 1'b1, 8'h5A, 2'b11);
`endif
        // Input changing 3 cycles before the terminal count.
        step();
        in = 8'hC3;
        repeat (2) step();
        step();
        check_all("early_change", 1'b1, 1'b1, 8'hC3, 2'b11);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tick_sampler.md
Name: tick_sampler

Overview:
- Parametrised successor to the single-channel slow-clock sample latch: samples CH input channels of WIDTH bits each at a runtime-programmable rate.
- Fully synchronous: no derived clock; the divider produces a one-cycle tick enable inside the clk domain.
- Adds enable/pause, runtime period reload, a change-only capture mode and per-channel change flags.
- Sits between raw game inputs (buttons, switches, sensor buses) and game logic that needs slow, stable snapshots.

Parameters:
- CH, 4, number of input channels.
- WIDTH, 1, bits per channel.
- CNT_W, 26, divider counter / period register width.
- DEFAULT_PERIOD, 24999999, period loaded at reset; tick interval is period+1 clk cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  divider run enable; 0 pauses the counter with its value held.
- period_in  input  CNT_W  new period value.
- period_load  input  1  one-cycle strobe; loads period_in and restarts the count.
- mode  input  1  0 = sample every tick; 1 = capture only when the input differs from out.
- in  input  CH*WIDTH  channel inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- out  output  CH*WIDTH  registered sampled data.
- tick  output  1  one-cycle pulse at each sample point.
- valid  output  1  one-cycle pulse: out was updated this cycle.
- changed  output  CH  per-channel flag: the channel differed at the last capture (held until the next tick).

Behaviour:
- Reset (rst=1 at posedge clk): cnt=0, period_reg=DEFAULT_PERIOD, out=0, tick=0, valid=0, changed=0.
  - Reset mid-count aborts the count. The next tick comes DEFAULT_PERIOD+1 enabled cycles after rst deasserts.
- Divider:
  - If period_load=1: period_reg<=period_in, cnt<=0, no tick, no capture. Load wins over a simultaneous terminal count and over en=0.
  - Else if en=0: cnt held, tick=0, valid=0.
  - Else if cnt==period_reg: cnt<=0 and a sample event occurs.
  - Else cnt<=cnt+1.
- period_reg=0 gives a tick every enabled cycle. All CNT_W values are legal; there is no overflow because cnt never exceeds period_reg.
- Sample event, all updates at the same edge; registered outputs are visible the following cycle:
  - tick<=1.
  - diff = per-channel compare of in against current out; changed[k]<=|(in_k ^ out_k).
  - mode=0: out<=in, valid<=1.
  - mode=1: if any diff then out<=in, valid<=1; else out held, valid<=0.
- Latency: in is sampled at the terminal-count edge. out, tick and valid are observable in the same cycle, one cycle after that edge.
- tick and valid are single-cycle pulses, cleared on every non-event cycle.
- changed is updated only on sample events and otherwise holds.
- Changing mode between ticks takes effect at the next sample event.

Optional Feature:
- Macro: TICK_SAMPLER_SYNC_EN.
- Defined: in passes through a 2-flop synchroniser, reset to 0, before the compare and capture stage. This adds 2 clk cycles of input-to-sample delay: the sampled value is in as it was 2 cycles before the terminal count.
- Undefined: in feeds the capture logic directly. The caller guarantees in is synchronous to clk.

Decomposition:
- Shared package: CNT_W default, DEFAULT_PERIOD, and mode encodings MODE_EVERY=1'b0 and MODE_CHANGE=1'b1.
- One sub-module, tick_gen: holds cnt and period_reg and drives the sample-event strobe. tick_gen is reusable for LED blink and game-step timing.
- Capture, compare and change logic stays in tick_sampler.

Test Plan:
- All Test Plan cases instantiate with DEFAULT_PERIOD=3, CH=2, WIDTH=4.
- Reset then en=1, mode=0, in=8'hA5 -> tick and valid high on cycles 4, 8, 12 after reset release; out=8'hA5 from cycle 4; changed=2'b11 at the first tick.
- mode=1, in held at 8'hA5 after capture -> tick pulses continue, valid stays 0, out=8'hA5, changed=2'b00. Then in=8'hA6 -> next tick gives valid=1, out=8'hA6, changed=2'b01.
- period_load with period_in=0 asserted in the cycle where cnt==3 -> no tick that cycle; afterwards tick every cycle.
- en=0 for 5 cycles at cnt=2 -> no tick while paused. After en=1, tick occurs 2 cycles later (cnt 2->3 then event).
- rst asserted at cnt=2 with out=8'hA6 -> next cycle out=0, tick=0, valid=0, changed=0; next tick 4 cycles after release.
- With TICK_SAMPLER_SYNC_EN defined: in changes 1 cycle before terminal count -> the old value is captured; a change 3 cycles before terminal count is captured.
